// File: rtl/out_fifo_arbiter.sv
// Two-requester, packet-atomic round-robin arbiter for the FPGA->FT2232 output FIFO write port.
// Packets that stall or run past MAX_PKT_BYTES are aborted and flagged on a one-cycle abort_o pulse.
module out_fifo_arbiter #(
   parameter int MAX_PKT_BYTES = 64,
   parameter int STALL_CLKS    = 255
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [1:0]  req_valid_i,
   input  logic [15:0] req_data_i,
   input  logic [1:0]  req_last_i,
   output logic [1:0]  req_ready_o,
   output logic        wr_out_fifo_en_o,
   output logic [7:0]  wr_out_fifo_data_o,
   input  logic        wr_out_fifo_full_i,
   input  logic        wr_out_fifo_afull_i,
   output logic [1:0]  grant_o,
   output logic        abort_o
);

   typedef enum logic [1:0] {ARB, XFER, DRAIN} state_t;

   localparam logic [7:0] MAX_BYTES = 8'(MAX_PKT_BYTES);
   localparam logic [7:0] STALL_LIM = 8'(STALL_CLKS);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [7:0] byte_cnt;
   logic [7:0] stall_cnt;

   logic       own_valid;
   logic       own_last;
   logic [7:0] own_data;
   logic       accept;
   logic       pick;
   logic [7:0] byte_inc;
   logic [7:0] stall_inc;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign own_valid = req_valid_i[owner];
   assign own_last  = req_last_i[owner];
   assign own_data  = owner ? req_data_i[15:8] : req_data_i[7:0];
   assign byte_inc  = sat_inc(byte_cnt);
   assign stall_inc = sat_inc(stall_cnt);

   // With both requesting, the one that did not own the last packet wins.
   assign pick = (req_valid_i == 2'b11) ? ~last_grant : req_valid_i[1];

   always_comb begin
      req_ready_o        = 2'b00;
      wr_out_fifo_en_o   = 1'b0;
      wr_out_fifo_data_o = 8'h00;
      case (state)
         XFER: begin
            req_ready_o[owner] = ~wr_out_fifo_full_i;
            wr_out_fifo_en_o   = own_valid & ~wr_out_fifo_full_i;
            wr_out_fifo_data_o = own_data;
         end
         DRAIN: begin
            req_ready_o[owner] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign accept = own_valid & req_ready_o[owner];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= ARB;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         byte_cnt   <= 8'd0;
         stall_cnt  <= 8'd0;
         grant_o    <= 2'b00;
         abort_o    <= 1'b0;
      end else begin
         abort_o <= 1'b0;
         case (state)
            ARB: begin
               if (!wr_out_fifo_afull_i && (req_valid_i != 2'b00)) begin
                  owner     <= pick;
                  grant_o   <= pick ? 2'b10 : 2'b01;
                  state     <= XFER;
                  byte_cnt  <= 8'd0;
                  stall_cnt <= 8'd0;
               end
            end
            XFER, DRAIN: begin
               if (accept) begin
                  byte_cnt  <= byte_inc;
                  stall_cnt <= 8'd0;
                  if (own_last) begin
                     state      <= ARB;
                     last_grant <= owner;
                     grant_o    <= 2'b00;
                  end else if ((state == XFER) && (byte_inc == MAX_BYTES)) begin
                     // Over-length: keep ownership and swallow the tail up to last.
                     abort_o <= 1'b1;
                     state   <= DRAIN;
                  end
               end else begin
                  stall_cnt <= stall_inc;
                  if (stall_inc == STALL_LIM) begin
                     abort_o    <= 1'b1;
                     state      <= ARB;
                     last_grant <= owner;
                     grant_o    <= 2'b00;
                  end
               end
            end
            default: begin
               state   <= ARB;
               grant_o <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// Directed bench for out_fifo_arbiter: inputs change on the falling edge, outputs checked 1 ns later.
module tb_out_fifo_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        wen;
   logic [7:0]  wdata;
   logic        full;
   logic        afull;
   logic [1:0]  grant;
   logic        abort;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_count;

   always #5 clk = ~clk;

   out_fifo_arbiter #(.MAX_PKT_BYTES(64), .STALL_CLKS(255)) dut (
      .clk_i               (clk),
      .reset_n_i           (reset_n),
      .req_valid_i         (req_valid),
      .req_data_i          (req_data),
      .req_last_i          (req_last),
      .req_ready_o         (req_ready),
      .wr_out_fifo_en_o    (wen),
      .wr_out_fifo_data_o  (wdata),
      .wr_out_fifo_full_i  (full),
      .wr_out_fifo_afull_i (afull),
      .grant_o             (grant),
      .abort_o             (abort)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                        input logic [1:0] l, input logic f, input logic af);
      @(negedge clk);
      req_valid = v;
      req_data  = {d1, d0};
      req_last  = l;
      full      = f;
      afull     = af;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] rdy, input logic en,
                             input logic [7:0] d, input logic [1:0] g, input logic ab);
      chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".wen"},   32'(wen),       32'(en));
      if (en) chk({tag, ".wdata"}, 32'(wdata), 32'(d));
      chk({tag, ".grant"}, 32'(grant),     32'(g));
      chk({tag, ".abort"}, 32'(abort),     32'(ab));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 2'b00;
      req_last  = 2'b00;
      full      = 1'b0;
      afull     = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 2'b00;
      req_data  = 16'h0000;
      req_last  = 2'b00;
      full      = 1'b0;
      afull     = 1'b0;
      #1;
      expect_out("rst", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      chk("rst.wdata", 32'(wdata), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: single 3-byte packet on req0
      drive(2'b01, 8'h00, 8'hA1, 2'b00, 1'b0, 1'b0);
      expect_out("t1_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b01, 8'h00, 8'hA1, 2'b00, 1'b0, 1'b0);
      expect_out("t1_b1", 2'b01, 1'b1, 8'hA1, 2'b01, 1'b0);
      drive(2'b01, 8'h00, 8'hA2, 2'b00, 1'b0, 1'b0);
      expect_out("t1_b2", 2'b01, 1'b1, 8'hA2, 2'b01, 1'b0);
      drive(2'b01, 8'h00, 8'hA3, 2'b01, 1'b0, 1'b0);
      expect_out("t1_b3", 2'b01, 1'b1, 8'hA3, 2'b01, 1'b0);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t1_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 2: both requesters contend with 2-byte packets, fresh priority
      do_reset();
      drive(2'b11, 8'h11, 8'h01, 2'b00, 1'b0, 1'b0);
      expect_out("t2_arb0", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b11, 8'h11, 8'h01, 2'b00, 1'b0, 1'b0);
      expect_out("t2_p0b1", 2'b01, 1'b1, 8'h01, 2'b01, 1'b0);
      drive(2'b11, 8'h11, 8'h02, 2'b01, 1'b0, 1'b0);
      expect_out("t2_p0b2", 2'b01, 1'b1, 8'h02, 2'b01, 1'b0);
      drive(2'b11, 8'h11, 8'h03, 2'b00, 1'b0, 1'b0);
      expect_out("t2_arb1", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b11, 8'h11, 8'h03, 2'b00, 1'b0, 1'b0);
      expect_out("t2_p1b1", 2'b10, 1'b1, 8'h11, 2'b10, 1'b0);
      drive(2'b11, 8'h12, 8'h03, 2'b10, 1'b0, 1'b0);
      expect_out("t2_p1b2", 2'b10, 1'b1, 8'h12, 2'b10, 1'b0);
      drive(2'b11, 8'h13, 8'h03, 2'b00, 1'b0, 1'b0);
      expect_out("t2_arb2", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b11, 8'h13, 8'h03, 2'b00, 1'b0, 1'b0);
      expect_out("t2_p2b1", 2'b01, 1'b1, 8'h03, 2'b01, 1'b0);
      drive(2'b11, 8'h13, 8'h04, 2'b01, 1'b0, 1'b0);
      expect_out("t2_p2b2", 2'b01, 1'b1, 8'h04, 2'b01, 1'b0);
      drive(2'b10, 8'h13, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t2_arb3", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b10, 8'h13, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t2_p3b1", 2'b10, 1'b1, 8'h13, 2'b10, 1'b0);
      drive(2'b10, 8'h14, 8'h00, 2'b10, 1'b0, 1'b0);
      expect_out("t2_p3b2", 2'b10, 1'b1, 8'h14, 2'b10, 1'b0);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t2_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 3: full for 4 clocks in mid-packet
      drive(2'b01, 8'h00, 8'h21, 2'b00, 1'b0, 1'b0);
      expect_out("t3_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b01, 8'h00, 8'h21, 2'b00, 1'b0, 1'b0);
      expect_out("t3_b1", 2'b01, 1'b1, 8'h21, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, 8'h00, 8'h22, 2'b00, 1'b1, 1'b0);
         expect_out($sformatf("t3_full%0d", i), 2'b00, 1'b0, 8'h00, 2'b01, 1'b0);
      end
      drive(2'b01, 8'h00, 8'h22, 2'b00, 1'b0, 1'b0);
      expect_out("t3_b2", 2'b01, 1'b1, 8'h22, 2'b01, 1'b0);
      drive(2'b01, 8'h00, 8'h23, 2'b01, 1'b0, 1'b0);
      expect_out("t3_b3", 2'b01, 1'b1, 8'h23, 2'b01, 1'b0);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t3_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 4: afull holds off the grant; afull inside a packet is ignored
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, 8'h31, 8'h00, 2'b00, 1'b0, 1'b1);
         expect_out($sformatf("t4_afull%0d", i), 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      end
      drive(2'b10, 8'h31, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t4_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b10, 8'h31, 8'h00, 2'b00, 1'b0, 1'b1);
      expect_out("t4_b1", 2'b10, 1'b1, 8'h31, 2'b10, 1'b0);
      drive(2'b10, 8'h32, 8'h00, 2'b10, 1'b0, 1'b1);
      expect_out("t4_b2", 2'b10, 1'b1, 8'h32, 2'b10, 1'b0);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t4_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 5: req0 granted then idles 255 clocks; req1 waits
      drive(2'b11, 8'h51, 8'h41, 2'b00, 1'b0, 1'b0);
      expect_out("t5_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      for (int i = 1; i <= 255; i++) begin
         drive(2'b10, 8'h51, 8'h41, 2'b00, 1'b0, 1'b0);
         expect_out($sformatf("t5_idle%0d", i), 2'b01, 1'b0, 8'h00, 2'b01, 1'b0);
      end
      drive(2'b10, 8'h51, 8'h41, 2'b00, 1'b0, 1'b0);
      expect_out("t5_abort", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
      drive(2'b10, 8'h51, 8'h41, 2'b10, 1'b0, 1'b0);
      expect_out("t5_req1", 2'b10, 1'b1, 8'h51, 2'b10, 1'b0);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t5_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 6: 70-byte packet against a 64-byte limit
      wr_count = 0;
      drive(2'b01, 8'h00, 8'd1, 2'b00, 1'b0, 1'b0);
      expect_out("t6_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      for (int i = 1; i <= 70; i++) begin
         drive(2'b01, 8'h00, 8'(i), (i == 70) ? 2'b01 : 2'b00, 1'b0, 1'b0);
         if (wen) wr_count++;
         if (i <= 64)
            expect_out($sformatf("t6_b%0d", i), 2'b01, 1'b1, 8'(i), 2'b01, 1'b0);
         else
            expect_out($sformatf("t6_drain%0d", i), 2'b01, 1'b0, 8'h00, 2'b01, (i == 65));
      end
      chk("t6_wr_count", 32'(wr_count), 32'd64);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t6_end", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // 7: reset in mid-packet drops the grant at once
      drive(2'b01, 8'h00, 8'h61, 2'b00, 1'b0, 1'b0);
      expect_out("t7_arb", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      drive(2'b01, 8'h00, 8'h61, 2'b00, 1'b0, 1'b0);
      expect_out("t7_b1", 2'b01, 1'b1, 8'h61, 2'b01, 1'b0);
      @(negedge clk);
      req_data = 16'h0062;
      reset_n  = 1'b0;
      #1;
      expect_out("t7_rst", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      req_valid = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
      expect_out("t7_after", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
